// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of one memory port between fetch, scalar LSU and vector LSU
module mem_port_arbiter #(
  parameter int ADDR_W = 36,
  parameter int DATA_W = 36,
  parameter int VLEN   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   f_req_valid,
  input  logic [ADDR_W-1:0]      f_req_addr,
  output logic                   f_req_ready,
  output logic                   f_resp_valid,
  output logic [DATA_W-1:0]      f_resp_data,
  input  logic                   s_req_valid,
  input  logic                   s_req_we,
  input  logic [ADDR_W-1:0]      s_req_addr,
  input  logic [DATA_W-1:0]      s_req_wdata,
  output logic                   s_req_ready,
  output logic                   s_resp_valid,
  output logic [DATA_W-1:0]      s_resp_data,
  input  logic                   v_req_valid,
  input  logic                   v_req_we,
  input  logic [ADDR_W-1:0]      v_req_addr,
  input  logic [DATA_W*VLEN-1:0] v_req_wdata,
  output logic                   v_req_ready,
  output logic                   v_resp_valid,
  output logic [DATA_W*VLEN-1:0] v_resp_data,
  output logic                   mem_req_valid,
  output logic                   mem_req_we,
  output logic [ADDR_W-1:0]      mem_req_addr,
  output logic [DATA_W-1:0]      mem_req_wdata,
  input  logic                   mem_req_ready,
  input  logic                   mem_resp_valid,
  input  logic [DATA_W-1:0]      mem_resp_data,
  output logic                   busy,
  output logic                   err
);
  localparam int BW = VLEN > 1 ? $clog2(VLEN) : 1;
  localparam int VW = DATA_W * VLEN;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t            state_q, state_d;
  logic [1:0]        last_q, last_d, id_q, id_d;
  logic [BW-1:0]     beat_q, beat_d, last_beat;
  logic              we_q, we_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [VW-1:0]     wdata_q, wdata_d, lanes_q, lanes_d;
  logic              f_resp_valid_q, f_resp_valid_d, s_resp_valid_q, s_resp_valid_d, v_resp_valid_q, v_resp_valid_d;
  logic [DATA_W-1:0] f_resp_data_q, f_resp_data_d, s_resp_data_q, s_resp_data_d;
  logic [VW-1:0]     v_resp_data_q, v_resp_data_d;
  logic [2:0]        vld;
  logic [1:0]        p0, p1, p2, sel;
  logic              grant;
  // Round-robin pick starting after the last owner; ready is gated by reset so it reads 0 while held
  always_comb begin
    vld   = {v_req_valid, s_req_valid, f_req_valid};
    p0    = last_q == 2'd2 ? 2'd0 : last_q + 2'd1;
    p1    = p0 == 2'd2 ? 2'd0 : p0 + 2'd1;
    p2    = p1 == 2'd2 ? 2'd0 : p1 + 2'd1;
    sel   = vld[p0] ? p0 : vld[p1] ? p1 : p2;
    grant = rst && state_q == IDLE && |vld;
  end
  assign f_req_ready   = grant && sel == 2'd0;
  assign s_req_ready   = grant && sel == 2'd1;
  assign v_req_ready   = grant && sel == 2'd2;
  assign busy          = state_q != IDLE;
  assign err           = err_q;
  assign mem_req_valid = state_q == ISSUE;
  assign mem_req_we    = mem_req_valid && we_q;
  assign mem_req_addr  = mem_req_valid ? addr_q + ADDR_W'(beat_q) : '0;
  assign mem_req_wdata = mem_req_valid ? wdata_q[int'(beat_q)*DATA_W +: DATA_W] : '0;
  assign f_resp_valid  = f_resp_valid_q;
  assign s_resp_valid  = s_resp_valid_q;
  assign v_resp_valid  = v_resp_valid_q;
  assign f_resp_data   = f_resp_data_q;
  assign s_resp_data   = s_resp_data_q;
  assign v_resp_data   = v_resp_data_q;
  // Next state: latch the winner, walk beats through ISSUE/WAIT, assemble lanes and emit the response
  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    id_d           = id_q;
    beat_d         = beat_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    lanes_d        = lanes_q;
    f_resp_valid_d = 1'b0;
    s_resp_valid_d = 1'b0;
    v_resp_valid_d = 1'b0;
    f_resp_data_d  = f_resp_data_q;
    s_resp_data_d  = s_resp_data_q;
    v_resp_data_d  = v_resp_data_q;
    err_d          = err_q || (mem_resp_valid && state_q != WAIT);
    last_beat      = id_q == 2'd2 ? BW'(VLEN - 1) : '0;
    case (state_q)
      IDLE: if (|vld) begin
        state_d = ISSUE;
        last_d  = sel;
        id_d    = sel;
        beat_d  = '0;
        we_d    = sel == 2'd1 ? s_req_we : sel == 2'd2 ? v_req_we : 1'b0;
        addr_d  = sel == 2'd0 ? f_req_addr : sel == 2'd1 ? s_req_addr : v_req_addr;
        wdata_d = sel == 2'd2 ? v_req_wdata : sel == 2'd1 ? VW'(s_req_wdata) : '0;
      end
      ISSUE: if (mem_req_ready) state_d = WAIT;
      WAIT: if (mem_resp_valid) begin
        lanes_d[int'(beat_q)*DATA_W +: DATA_W] = mem_resp_data;
        if (beat_q != last_beat) begin
          beat_d  = beat_q + BW'(1);
          state_d = ISSUE;
        end else begin
          state_d        = IDLE;
          f_resp_valid_d = id_q == 2'd0;
          s_resp_valid_d = id_q == 2'd1;
          v_resp_valid_d = id_q == 2'd2;
          f_resp_data_d  = id_q == 2'd0 ? lanes_d[DATA_W-1:0] : f_resp_data_q;
          s_resp_data_d  = id_q == 2'd1 ? (we_q ? '0 : lanes_d[DATA_W-1:0]) : s_resp_data_q;
          v_resp_data_d  = id_q == 2'd2 ? (we_q ? '0 : lanes_d) : v_resp_data_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // State registers; reset abandons any transaction and makes fetch the first winner
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      last_q         <= 2'd2;
      id_q           <= 2'd0;
      beat_q         <= '0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      lanes_q        <= '0;
      f_resp_valid_q <= 1'b0;
      s_resp_valid_q <= 1'b0;
      v_resp_valid_q <= 1'b0;
      f_resp_data_q  <= '0;
      s_resp_data_q  <= '0;
      v_resp_data_q  <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_q         <= last_d;
      id_q           <= id_d;
      beat_q         <= beat_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      lanes_q        <= lanes_d;
      f_resp_valid_q <= f_resp_valid_d;
      s_resp_valid_q <= s_resp_valid_d;
      v_resp_valid_q <= v_resp_valid_d;
      f_resp_data_q  <= f_resp_data_d;
      s_resp_data_q  <= s_resp_data_d;
      v_resp_data_q  <= v_resp_data_d;
      err_q          <= err_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, beat splitting, stalls, err and reset
module tb_mem_port_arbiter;
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          f_req_valid = 1'b0, f_req_ready, f_resp_valid;
  logic [35:0]   f_req_addr = '0, f_resp_data;
  logic          s_req_valid = 1'b0, s_req_we = 1'b0, s_req_ready, s_resp_valid;
  logic [35:0]   s_req_addr = '0, s_req_wdata = '0, s_resp_data;
  logic          v_req_valid = 1'b0, v_req_we = 1'b0, v_req_ready, v_resp_valid;
  logic [35:0]   v_req_addr = '0;
  logic [143:0]  v_req_wdata = '0, v_resp_data;
  logic          mem_req_valid, mem_req_we, mem_req_ready = 1'b1, mem_resp_valid = 1'b0;
  logic [35:0]   mem_req_addr, mem_req_wdata, mem_resp_data = '0;
  logic          busy, err;
  int            checks = 0, errors = 0, cyc;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(36), .DATA_W(36), .VLEN(4)) dut (
    .clk(clk), .rst(rst),
    .f_req_valid(f_req_valid), .f_req_addr(f_req_addr), .f_req_ready(f_req_ready),
    .f_resp_valid(f_resp_valid), .f_resp_data(f_resp_data),
    .s_req_valid(s_req_valid), .s_req_we(s_req_we), .s_req_addr(s_req_addr), .s_req_wdata(s_req_wdata),
    .s_req_ready(s_req_ready), .s_resp_valid(s_resp_valid), .s_resp_data(s_resp_data),
    .v_req_valid(v_req_valid), .v_req_we(v_req_we), .v_req_addr(v_req_addr), .v_req_wdata(v_req_wdata),
    .v_req_ready(v_req_ready), .v_resp_valid(v_resp_valid), .v_resp_data(v_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .busy(busy), .err(err)
  );

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction from its accept cycle to its response cycle; memory answers every beat at once
  task automatic txn(input int id, input int nb, input logic we, input logic [35:0] a0,
                     input logic [143:0] wd, input logic [35:0] rb, input int stall_beat,
                     input int stall_n, input bit drop, output int ncyc);
    logic [143:0] exp_r;
    logic [35:0]  ea;
    exp_r = '0;
    ncyc  = 0;
    chk("accept_ready", {v_req_ready, s_req_ready, f_req_ready}, 3'b001 << id);
    for (int b = 0; b < nb; b++) begin
      @(negedge clk); ncyc++;
      mem_resp_valid = 1'b0;
      if (drop) begin f_req_valid = 1'b0; s_req_valid = 1'b0; v_req_valid = 1'b0; end
      ea = a0 + 36'(b);
      if (b == stall_beat) begin
        mem_req_ready = 1'b0;
        for (int k = 0; k < stall_n; k++) begin
          if (k > 0) begin @(negedge clk); ncyc++; end
          #1;
          chk("stall_valid", mem_req_valid, 1'b1);
          chk("stall_addr", mem_req_addr, ea);
          chk("stall_wdata", mem_req_wdata, wd[b*36 +: 36]);
        end
        @(negedge clk); ncyc++;
        mem_req_ready = 1'b1;
      end
      #1;
      chk("issue_valid", mem_req_valid, 1'b1);
      chk("issue_addr", mem_req_addr, ea);
      chk("issue_we", mem_req_we, we);
      chk("issue_busy", busy, 1'b1);
      if (we) chk("issue_wdata", mem_req_wdata, wd[b*36 +: 36]);
      @(negedge clk); ncyc++;
      mem_resp_valid = 1'b1;
      mem_resp_data  = rb + 36'(b);
      if (!we) exp_r[b*36 +: 36] = rb + 36'(b);
      #1;
      chk("wait_busy", busy, 1'b1);
      chk("wait_mvalid", mem_req_valid, 1'b0);
    end
    @(negedge clk); ncyc++;
    mem_resp_valid = 1'b0;
    #1;
    chk("resp_valid", {v_resp_valid, s_resp_valid, f_resp_valid}, 3'b001 << id);
    chk("resp_data", id == 2 ? v_resp_data : id == 1 ? 144'(s_resp_data) : 144'(f_resp_data), exp_r);
    chk("resp_busy", busy, 1'b0);
    chk("resp_err", err, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
  endtask

  initial begin
    // Reset state with a pending fetch: nothing may be granted
    f_req_valid = 1'b1;
    @(negedge clk); #1;
    chk("rst_ready", {v_req_ready, s_req_ready, f_req_ready}, 3'b000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_mem", {mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata}, '0);
    chk("rst_resp", {v_resp_valid, s_resp_valid, f_resp_valid}, 3'b000);
    chk("rst_rdata", {v_resp_data, s_resp_data, f_resp_data}, '0);
    f_req_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    // Scalar load, latency 3 cycles from accept
    @(negedge clk);
    s_req_valid = 1'b1; s_req_we = 1'b0; s_req_addr = 36'h000000010;
    #1;
    txn(1, 1, 1'b0, 36'h000000010, '0, 36'h123456789, -1, 0, 1'b1, cyc);
    chk("scalar_latency", cyc, 3);
    @(negedge clk); #1;
    chk("scalar_pulse", s_resp_valid, 1'b0);
    chk("scalar_hold", s_resp_data, 36'h123456789);
    // All three valid from reset: fetch, scalar, vector, fetch
    do_reset();
    f_req_valid = 1'b1; f_req_addr = 36'h100;
    s_req_valid = 1'b1; s_req_we = 1'b0; s_req_addr = 36'h200;
    v_req_valid = 1'b1; v_req_we = 1'b0; v_req_addr = 36'h300;
    #1;
    txn(0, 1, 1'b0, 36'h100, '0, 36'hA00, -1, 0, 1'b0, cyc);
    txn(1, 1, 1'b0, 36'h200, '0, 36'hB00, -1, 0, 1'b0, cyc);
    txn(2, 4, 1'b0, 36'h300, '0, 36'hC00, -1, 0, 1'b0, cyc);
    chk("vec_latency", cyc, 9);
    txn(0, 1, 1'b0, 36'h100, '0, 36'hA10, -1, 0, 1'b1, cyc);
    // Vector store wrapping around the top of the address space
    @(negedge clk);
    v_req_valid = 1'b1; v_req_we = 1'b1; v_req_addr = 36'hFFFFFFFFE;
    v_req_wdata = {36'd4, 36'd3, 36'd2, 36'd1};
    #1;
    txn(2, 4, 1'b1, 36'hFFFFFFFFE, {36'd4, 36'd3, 36'd2, 36'd1}, 36'hDEAD0, -1, 0, 1'b1, cyc);
    // Vector load with beat 2 stalled 3 cycles
    @(negedge clk);
    v_req_valid = 1'b1; v_req_we = 1'b0; v_req_addr = 36'h40; v_req_wdata = '0;
    #1;
    txn(2, 4, 1'b0, 36'h40, '0, 36'h700, 2, 3, 1'b1, cyc);
    chk("stall_latency", cyc, 12);
    // Spurious memory response while idle
    @(negedge clk);
    mem_resp_valid = 1'b1; mem_resp_data = 36'h55;
    #1;
    chk("spur_err_now", err, 1'b0);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    chk("spur_err", err, 1'b1);
    chk("spur_resp", {v_resp_valid, s_resp_valid, f_resp_valid}, 3'b000);
    @(negedge clk); #1;
    chk("spur_sticky", err, 1'b1);
    // Reset during WAIT of vector beat 1
    @(negedge clk);
    v_req_valid = 1'b1; v_req_we = 1'b0; v_req_addr = 36'h80;
    #1;
    chk("mid_ready", v_req_ready, 1'b1);
    @(negedge clk);
    v_req_valid = 1'b0;
    #1;
    chk("mid_addr0", mem_req_addr, 36'h80);
    @(negedge clk);
    mem_resp_valid = 1'b1; mem_resp_data = 36'h1;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    chk("mid_addr1", mem_req_addr, 36'h81);
    @(negedge clk); #1;
    chk("mid_busy", busy, 1'b1);
    #1 rst = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_err", err, 1'b0);
    chk("arst_mem", {mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata}, '0);
    chk("arst_resp", {v_resp_valid, s_resp_valid, f_resp_valid}, 3'b000);
    chk("arst_rdata", v_resp_data, '0);
    f_req_valid = 1'b1; s_req_valid = 1'b1; v_req_valid = 1'b1;
    @(negedge clk); #1;
    chk("arst_ready", {v_req_ready, s_req_ready, f_req_ready}, 3'b000);
    chk("arst_noresp", v_resp_valid, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_rst_fetch", {v_req_ready, s_req_ready, f_req_ready}, 3'b001);
    chk("post_rst_noresp", v_resp_valid, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
